f2h_input_conditioner: RTL
==========================

# f2h_input_conditioner

Conditions raw FPGA-side inputs (switches, buttons, status lines) before they reach the FPGA-to-HPS input PIO. Each bit is synchronized into `clk`, debounced, and presented as a stable value on `f2h_value`, which drives the PIO `in_port` directly. An optional sticky rising-edge capture register, with a per-bit clear and a masked interrupt, lets software catch short presses that occur between polls.

## Interface
- `WIDTH`, 8: number of conditioned bits; matches the PIO `in_port` width.
- `SYNC_STAGES`, 2: synchronizer flops per bit; legal range 2..4.
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles a new level must persist before it is accepted (1 ms at 50 MHz); must be ≥1.
- `clk`  in  1: single clock; the same clock as the PIO.
- `reset`  in  1: synchronous, active-high reset.
- `raw_in`  in  WIDTH: asynchronous raw inputs.
- `f2h_value`  out  WIDTH: debounced stable levels; feeds PIO `in_port`.
- `edge_clear`  in  WIDTH: per-bit single-cycle clear of the edge flags (only with `F2H_EDGE_CAPTURE_EN`).
- `edge_mask`  in  WIDTH: per-bit interrupt enable (only with `F2H_EDGE_CAPTURE_EN`).
- `f2h_edge`  out  WIDTH: sticky rising-edge flags (only with `F2H_EDGE_CAPTURE_EN`).
- `f2h_irq`  out  1: registered OR of `f2h_edge & edge_mask` (only with `F2H_EDGE_CAPTURE_EN`).

## Operation
- All bits are independent and identical; there is no cross-bit interaction.
- **Synchronizer:** `raw_in[i]` passes through a `SYNC_STAGES`-deep flop chain. `sync[i]` is the last stage.
- **Debounce:** each bit has a stable flop `stable[i]` and a counter `cnt[i]` of width `$clog2(DEBOUNCE_CYCLES+1)`. The two states are:
  - IDLE (`sync == stable`): `cnt` is held at 0.
  - PENDING (`sync != stable`): `cnt` increments by 1 each cycle.
  - When `cnt == DEBOUNCE_CYCLES-1` while PENDING, then on the next edge `stable <= sync` and `cnt <= 0`.
  - If `sync` returns to `stable` before that point, `cnt <= 0` (glitch rejected). A partial count never carries over.
- The counter never wraps: it saturates by construction at `DEBOUNCE_CYCLES-1`.
- `f2h_value = stable` (a registered output, with no combinational path from `raw_in`).
- **Edge capture** (macro on):
  - `rise[i] = stable_next[i] & ~stable[i]`.
  - `edge[i] <= rise[i] | (edge[i] & ~edge_clear[i])`.
  - If a rise and a clear occur in the same cycle, set wins.
- **IRQ:** `f2h_irq <= |(edge_next & edge_mask)`. Changing the mask affects `f2h_irq` one cycle later.
- **Reset values:** all synchronizer flops, `stable`, `cnt`, `f2h_edge` and `f2h_irq` are 0. Reset mid-count discards the pending count.
- **After reset:** an input held high is accepted as a new level after the normal debounce delay. That acceptance does produce a rising edge, which is intended: software sees buttons that were held through reset.

## Timing
- Let `raw_in[i]` change before clock edge N and hold steady. Then:
  - `sync[i]` changes at edge N+SYNC_STAGES-1.
  - `f2h_value[i]` changes at edge N+SYNC_STAGES-1+DEBOUNCE_CYCLES.
- `f2h_edge[i]` sets on the same edge that `f2h_value[i]` rises.
- `f2h_irq` asserts on that same edge if the mask bit is set.
- `edge_clear` is sampled at edge M; `f2h_edge` reads 0 after edge M unless a rise also occurs at M.
- A pulse on `raw_in` shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) never reaches `f2h_value`.
- The PIO adds one further register, so software reads the value one cycle after `f2h_value` changes.

## Configuration
- Macro: `F2H_EDGE_CAPTURE_EN`.
- **Defined:** `edge_clear`, `edge_mask`, `f2h_edge` and `f2h_irq` exist, and the edge register and IRQ flop are built.
- **Undefined:** those four ports and their logic are absent. The block is synchronizer plus debounce only, and `f2h_value` behaviour is identical in both builds.

## Structure
- **Package `f2h_cond_pkg`:**
  - `F2H_WIDTH_DEFAULT = 8`.
  - `F2H_SYNC_STAGES_DEFAULT = 2`.
  - `F2H_DEBOUNCE_DEFAULT = 50000`.
  - A constant function `f2h_cnt_width(cycles)` returning the `cnt` width.
- **Sub-module `f2h_debounce_bit`:** one synchronizer, stable flop and counter, with parameters `SYNC_STAGES` and `DEBOUNCE_CYCLES`. The top level instantiates it `WIDTH` times in a generate loop.
- Edge capture and IRQ stay in the top level.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 unless stated otherwise.
- **Clean step:** drive `raw_in=8'h01` before edge N, after reset -> `f2h_value` goes from `8'h00` to `8'h01` at edge N+5, and `f2h_edge[0]=1` and `f2h_irq=1` at N+5 with mask `8'hFF`.
- **Glitch rejection:** 3-cycle high pulse on `raw_in[3]` -> `f2h_value` and `f2h_edge` stay `8'h00`; a 4-cycle pulse -> `f2h_value[3]` rises then falls, and `f2h_edge[3]` stays 1.
- **Clear/set collision:** assert `edge_clear[0]` on the same edge `f2h_value[0]` rises -> `f2h_edge[0]=1`; assert `edge_clear[0]` one cycle later -> 0, and `f2h_irq` deasserts the following cycle.
- **Mask:** `edge_mask=8'h00` with `raw_in=8'hFF` -> `f2h_edge=8'hFF` and `f2h_irq=0`; set mask to `8'h80` -> `f2h_irq=1` one cycle later.
- **Reset mid-count:** raw rises, reset is asserted 2 cycles into PENDING and released -> `f2h_value` rises only 5 cycles after release, not earlier.
- **DEBOUNCE_CYCLES=1 build with macro undefined:** step `raw_in=8'hA5` -> `f2h_value=8'hA5` 2 edges later, and the edge ports are absent.

Source files
------------

// File: rtl/f2h_cond_pkg.sv
// rtl/f2h_cond_pkg.sv - shared defaults and counter sizing for the f2h input conditioner
package f2h_cond_pkg;

  localparam int F2H_WIDTH_DEFAULT       = 8;
  localparam int F2H_SYNC_STAGES_DEFAULT = 2;
  localparam int F2H_DEBOUNCE_DEFAULT    = 50000;

  // Width of the per-bit debounce counter for a given acceptance delay.
  function automatic int f2h_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/f2h_debounce_bit.sv
// rtl/f2h_debounce_bit.sv - one-bit synchronizer, debounce counter and stable flop
module f2h_debounce_bit
  import f2h_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = F2H_SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = F2H_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic stable_next
);

  localparam int CW = f2h_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // Count while the synchronized level differs from the accepted one; any
  // return to the accepted level drops the partial count.
  always_comb begin
    stable_next = stable;
    cnt_next    = '0;
    if (sync != stable) begin
      if (cnt == CNT_LAST) begin
        stable_next = sync;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Register the accepted level and the pending count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      stable <= stable_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/f2h_input_conditioner.sv
// rtl/f2h_input_conditioner.sv - debounced FPGA-to-HPS inputs, optional edge capture under F2H_EDGE_CAPTURE_EN
module f2h_input_conditioner
  import f2h_cond_pkg::*;
#(
  parameter int WIDTH           = F2H_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = F2H_SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = F2H_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] f2h_value
`ifdef F2H_EDGE_CAPTURE_EN
  ,
  input  logic [WIDTH-1:0] edge_clear,
  input  logic [WIDTH-1:0] edge_mask,
  output logic [WIDTH-1:0] f2h_edge,
  output logic             f2h_irq
`endif
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    f2h_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .raw        (raw_in[i]),
      .stable     (stable[i]),
      .stable_next(stable_next[i])
    );
  end

  assign f2h_value = stable;

`ifdef F2H_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_next;
  logic [WIDTH-1:0] rise;

  // A newly accepted high level sets its flag; a same-cycle clear loses.
  always_comb begin
    rise      = stable_next & ~stable;
    edge_next = rise | (edge_q & ~edge_clear);
  end

  // Hold the sticky flags and the masked interrupt in registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q  <= '0;
      f2h_irq <= 1'b0;
    end else begin
      edge_q  <= edge_next;
      f2h_irq <= |(edge_next & edge_mask);
    end
  end

  assign f2h_edge = edge_q;
`else
  logic unused_stable_next;
  assign unused_stable_next = ^stable_next;
`endif

endmodule
